// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch and data ports,
// data first, with a watchdog that turns a missing memory ack into a sticky error.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
    state_t state, state_nx;
    logic own_d, we, busy, expire;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        busy = state == BUSY_I || state == BUSY_D;
        expire = busy && !mem_ack_i && cnt == CW'(TIMEOUT - 1);
        state_nx = state == IDLE ? (dm_req_i ? BUSY_D : if_req_i ? BUSY_I : IDLE) :
                   state == DONE ? IDLE :
                   (mem_ack_i || expire) ? DONE : state;
        mem_enable_o = busy;
        mem_write_o = state == BUSY_D && we;
        if_ack_o = state == DONE && !own_d;
        dm_ack_o = state == DONE && own_d;
    end
    assign stall_o = (if_req_i && !if_ack_o) || (dm_req_i && !dm_ack_o);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            own_d <= 1'b0;
            we <= 1'b0;
            cnt <= '0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            if_data_o <= '0;
            dm_rdata_o <= '0;
            err_o <= 1'b0;
        end else begin
            if (state == IDLE && dm_req_i) begin
                own_d <= 1'b1;
                we <= dm_we_i;
                mem_addr_o <= dm_addr_i;
                mem_data_o <= dm_wdata_i;
            end else if (state == IDLE && if_req_i) begin
                own_d <= 1'b0;
                we <= 1'b0;
                mem_addr_o <= if_addr_i;
            end
            cnt <= busy ? cnt + 1'b1 : '0;
            // a write never touches dm_rdata_o, not even when it times out
            if (busy && mem_ack_i) begin
                if (state == BUSY_I) if_data_o <= mem_data_i;
                else if (!we) dm_rdata_o <= mem_data_i;
            end else if (expire) begin
                err_o <= 1'b1;
                if (state == BUSY_I) if_data_o <= '0;
                else if (!we) dm_rdata_o <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, hand-written corner sequences and random accesses
// against a transaction-level model of mem_port_arbiter.
module tb_mem_port_arbiter;
    localparam int TMO = 8;
    logic        clk_i = 0, rst_i;
    logic        if_req_i, dm_req_i, dm_we_i, mem_ack_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_data_i;
    logic [31:0] if_data_o, dm_rdata_o, mem_addr_o, mem_data_o;
    logic        if_ack_o, dm_ack_o, mem_enable_o, mem_write_o, stall_o, err_o;
    int total = 0, bad = 0;
    logic [31:0] m_if, m_dm;
    bit m_err;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr, wdata, mdata;
        int          dly;
        int          exp_lat;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Spec-level outcome of one access: the memory acks in enable cycle dly (0 = never).
    function automatic void model(input bit is_d, input bit we, input logic [31:0] mdata,
                                  input int dly, output int lat, output logic [31:0] data);
        bit to = dly == 0 || dly > TMO;
        lat = to ? TMO + 1 : dly + 1;
        if (to) m_err = 1;
        if (!is_d) m_if = to ? 32'h0 : mdata;
        else if (!we) m_dm = to ? 32'h0 : mdata;
        data = is_d ? m_dm : m_if;
    endfunction

    // Drives one request and plays the memory; lat counts cycles from request to ack.
    task automatic access(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] mdata, input int dly,
                          output int lat, output logic [31:0] dat, output bit err, output bit sok);
        int en = 0;
        logic ack;
        lat = -1; dat = 'x; err = 0; sok = 1;
        @(negedge clk_i);
        if (is_d) begin
            dm_req_i = 1; dm_we_i = we; dm_addr_i = addr; dm_wdata_i = wdata;
        end else begin
            if_req_i = 1; if_addr_i = addr;
        end
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk_i);
            if (mem_enable_o) begin
                en++;
                if (mem_addr_o !== addr || mem_write_o !== (is_d && we) || (is_d && we && mem_data_o !== wdata))
                    sok = 0;
            end
            ack = is_d ? dm_ack_o : if_ack_o;
            if (ack) begin
                lat = c; dat = is_d ? dm_rdata_o : if_data_o; err = err_o;
                if (stall_o !== 0 || mem_enable_o !== 0 || (is_d ? if_ack_o : dm_ack_o) !== 0) sok = 0;
                dm_req_i = 0; if_req_i = 0;
            end else if (stall_o !== 1 || if_ack_o !== 0 || dm_ack_o !== 0) sok = 0;
            mem_ack_i = mem_enable_o && en == dly;
            mem_data_i = mem_ack_i ? mdata : ~mdata;
        end
        dm_req_i = 0; if_req_i = 0; mem_ack_i = 0;
    endtask

    task automatic run_one(input string nm, input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] mdata, input int dly,
                           output int lat, output logic [31:0] dat, output bit err);
        bit sok;
        int mlat;
        logic [31:0] mdat;
        access(is_d, we, addr, wdata, mdata, dly, lat, dat, err, sok);
        model(is_d, we, mdata, dly, mlat, mdat);
        chk({nm, "_lat"}, 32'(lat), 32'(mlat));
        chk({nm, "_data"}, dat, mdat);
        chk({nm, "_err"}, 32'(err), 32'(m_err));
        chk({nm, "_if_hold"}, if_data_o, m_if);
        chk({nm, "_dm_hold"}, dm_rdata_o, m_dm);
        chk({nm, "_bus"}, 32'(sok), 32'd1);
    endtask

    initial begin
        int lat, ca, cb, en;
        logic [31:0] dat;
        bit err, sok, seen;
        tbl[0] = '{0, 0, 32'h100, 32'h0, 32'h8C220004, 4, 5, 32'h8C220004, 0};
        tbl[1] = '{1, 0, 32'h40, 32'h0, 32'h11111111, 1, 2, 32'h11111111, 0};
        tbl[2] = '{1, 1, 32'h10, 32'hDEADBEEF, 32'h55555555, 3, 4, 32'h11111111, 0};
        tbl[3] = '{1, 0, 32'h20, 32'h0, 32'h22222222, 8, 9, 32'h22222222, 0};
        tbl[4] = '{0, 0, 32'h104, 32'h0, 32'h33333333, 2, 3, 32'h33333333, 0};
        tbl[5] = '{1, 0, 32'h30, 32'h0, 32'h99999999, 0, 9, 32'h0, 1};
        tbl[6] = '{0, 0, 32'h108, 32'h0, 32'h88888888, 9, 9, 32'h0, 1};
        tbl[7] = '{1, 0, 32'h44, 32'h0, 32'h44444444, 5, 6, 32'h44444444, 1};
        tbl[8] = '{0, 0, 32'h10C, 32'h0, 32'h66666666, 1, 2, 32'h66666666, 1};
        rst_i = 1; if_req_i = 0; dm_req_i = 0; dm_we_i = 0; mem_ack_i = 0;
        if_addr_i = 0; dm_addr_i = 0; dm_wdata_i = 0; mem_data_i = 0;
        m_if = 0; m_dm = 0; m_err = 0;
        repeat (2) @(negedge clk_i);
        chk("rst_enable", 32'(mem_enable_o), 0);
        chk("rst_write", 32'(mem_write_o), 0);
        chk("rst_acks", {30'b0, if_ack_o, dm_ack_o}, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_if_data", if_data_o, 0);
        chk("rst_dm_data", dm_rdata_o, 0);
        chk("rst_stall", 32'(stall_o), 0);
        rst_i = 0;

        for (int i = 0; i < 9; i++) begin
            run_one($sformatf("tbl%0d", i), tbl[i].is_d, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                    tbl[i].mdata, tbl[i].dly, lat, dat, err);
            chk($sformatf("tbl%0d_lat_vec", i), 32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("tbl%0d_data_vec", i), dat, tbl[i].exp_data);
            chk($sformatf("tbl%0d_err_vec", i), 32'(err), 32'(tbl[i].exp_err));
        end

        // both ports request together: data first, fetch on the following IDLE
        @(negedge clk_i);
        if_req_i = 1; if_addr_i = 32'h200; dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h40;
        en = 0; ca = -1; cb = -1; sok = 1;
        for (int c = 1; c <= 40 && cb < 0; c++) begin
            @(negedge clk_i);
            if (mem_enable_o) en++;
            if (dm_ack_o) begin
                ca = c; chk("both_dm_data", dm_rdata_o, 32'hA0A0A0A0); dm_req_i = 0; en = 0;
            end
            if (if_ack_o) begin
                cb = c; chk("both_if_data", if_data_o, 32'hB1B1B1B1);
                if (stall_o !== 0) sok = 0;
                if_req_i = 0;
            end else if (stall_o !== 1) sok = 0;
            mem_ack_i = mem_enable_o && en == 2;
            mem_data_i = mem_addr_o == 32'h40 ? 32'hA0A0A0A0 : 32'hB1B1B1B1;
        end
        mem_ack_i = 0; if_req_i = 0; dm_req_i = 0;
        chk("both_dm_cycle", 32'(ca), 3);
        chk("both_if_cycle", 32'(cb), 7);
        chk("both_stall", 32'(sok), 1);
        m_dm = 32'hA0A0A0A0; m_if = 32'hB1B1B1B1;

        // reset mid-fetch, then a stray ack after release
        @(negedge clk_i);
        if_req_i = 1; if_addr_i = 32'h300;
        repeat (2) @(negedge clk_i);
        chk("rst_mid_busy", 32'(mem_enable_o), 1);
        rst_i = 1; if_req_i = 0;
        #1;
        chk("rst_mid_enable", 32'(mem_enable_o), 0);
        chk("rst_mid_addr", mem_addr_o, 0);
        chk("rst_mid_if_data", if_data_o, 0);
        chk("rst_mid_dm_data", dm_rdata_o, 0);
        chk("rst_mid_err", 32'(err_o), 0);
        chk("rst_mid_acks", {30'b0, if_ack_o, dm_ack_o}, 0);
        @(negedge clk_i); rst_i = 0;
        @(negedge clk_i); mem_ack_i = 1; mem_data_i = 32'h77777777;
        @(negedge clk_i); mem_ack_i = 0;
        seen = 0;
        repeat (4) begin
            @(negedge clk_i);
            seen |= if_ack_o | dm_ack_o | mem_enable_o;
        end
        chk("late_ack_ignored", 32'(seen), 0);
        m_if = 0; m_dm = 0; m_err = 0;
        run_one("post_rst", 0, 0, 32'h400, 32'h0, 32'h12345678, 3, lat, dat, err);

        for (int i = 0; i < 40; i++) begin
            bit is_d = 1'($urandom_range(0, 1));
            bit we = is_d && $urandom_range(0, 2) == 0;
            run_one($sformatf("rnd%0d", i), is_d, we, $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 10)), lat, dat, err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
